adder_rr_scheduler: RTL
=======================

Name: adder_rr_scheduler

Overview:
- Shares one 32-bit RippleCarryAdder instance between NUM_REQ requesters.
- Grants requesters round-robin and holds the chosen operands on the adder for SETTLE_CYCLES clock cycles so the ripple chain settles.
- Registers sum, carry-out and signed overflow, then returns them on a valid/ready response channel tagged with the requester id.
- Sits between client blocks and the adder as its only driver.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- SETTLE_CYCLES, 2, cycles operands are held before the result is captured; must be at least 1, and 0 is an elaboration error.
- ID_W, max(1,$clog2(NUM_REQ)), width of the requester id. Derived; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  input  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  input  NUM_REQ*32  operand B, same packing as req_a.
- req_cin  input  NUM_REQ  carry-in per requester.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  32  sum.
- rsp_cout  output  1  carry out of bit 31.
- rsp_overflow  output  1  signed overflow.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, ptr=0, counter=0.
  - Operand and id registers = 0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_overflow=0, busy=0.
  - req_ready is forced to all-zero while rst is high.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Grant g is the first index with req_valid set, searching ptr, ptr+1, …, wrapping at NUM_REQ-1 to 0.
  - req_ready[g]=1 combinationally, in IDLE only. The handshake completes in that same cycle.
  - On the clock edge: capture a, b, cin and id g into the operand registers; counter<=SETTLE_CYCLES-1; ptr<=(g==NUM_REQ-1)?0:g+1; go to SETTLE.
  - With no req_valid set: stay in IDLE; ptr is unchanged.
- SETTLE:
  - The operand registers drive the adder directly.
  - Each edge: if counter!=0, counter decrements. If counter==0, capture the adder outputs into rsp_sum, rsp_cout and rsp_overflow, set rsp_valid<=1, and go to RESP.
- RESP:
  - All rsp_* outputs are held stable and req_ready=0.
  - When rsp_valid&&rsp_ready at an edge: rsp_valid<=0, go to IDLE. The result registers keep their last value.
- Latency and throughput:
  - A request accepted at edge T gives rsp_valid=1 after edge T+SETTLE_CYCLES.
  - Minimum spacing between grants is SETTLE_CYCLES+2 cycles.
- Arithmetic:
  - sum = a+b+cin, modulo 2^32.
  - cout = bit 32 of the sum.
  - overflow = (a[31]==b[31]) && (sum[31]!=a[31]).
- Requester rules:
  - A requester holds valid and data stable until it sees ready.
  - A drop of valid before grant is legal and is simply not granted.
- NUM_REQ=1: ptr stays 0 and rsp_id is the constant 0.
- Reset mid-operation: any in-flight operation is discarded and no response is produced.

Decomposition:
- Package adder_sched_pkg holds:
  - DATA_W=32.
  - The state enum {IDLE, SETTLE, RESP}.
  - An id-width function implementing max(1,$clog2(n)).
- Sub-module rr_arbiter (combinational, parameter N):
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant, grant index and any_req.
- The top module contains the FSM, counter, registers and one RippleCarryAdder instance.

Test Plan:
- Basic add: only req0 valid, a=0x00000005, b=0x00000003, cin=0, rsp_ready=1.
  -> req_ready[0] pulses for 1 cycle.
  -> rsp_valid rises after edge T+2 with sum=0x00000008, id=0, cout=0, overflow=0.
- Flag cases:
  -> a=0x7FFFFFFF, b=0x00000001, cin=0 gives sum=0x80000000, overflow=1, cout=0.
  -> a=0xFFFFFFFF, b=0x00000000, cin=1 gives sum=0x00000000, cout=1, overflow=0.
  -> a=0x80000000, b=0x80000000 gives sum=0, cout=1, overflow=1.
- Round-robin: all four req_valid held high with rsp_ready=1.
  -> Grant order is 0,1,2,3,0,1.
  -> rsp_id follows that order, with exactly SETTLE_CYCLES+2 cycles between grants.
- Pointer fairness: grant req2 alone, then raise req0 and req3 together.
  -> req3 is granted first, then req0.
- Backpressure: hold rsp_ready low for 10 cycles while all requests are valid.
  -> rsp_* stay stable, req_ready=0, busy=1 throughout.
  -> Raise rsp_ready for 1 cycle: one handshake completes, then the next grant occurs in the following cycle.
- Reset in SETTLE: assert rst asynchronously mid-count.
  -> rsp_valid=0, busy=0, ptr=0 immediately.
  -> After release with req1 and req3 valid, req1 is granted first.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
// The id-width helper is max(1, clog2(n)) and sizes both ids and counters.
package adder_sched_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_arb.sv
// Combinational round-robin arbiter. It picks the first requester at or after
// ptr, wrapping from index N-1 back to 0.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  int idx;

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      // ptr is always below N, so a single subtraction wraps the index.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    grant = any_req ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder. It is purely combinational, so callers must hold
// the operands steady long enough for the carry chain to settle.
module RippleCarryAdder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one ripple-carry adder between NUM_REQ requesters. Requesters are
// granted round-robin, operands are held for SETTLE_CYCLES, and the result is returned.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int SETTLE_CYCLES = 2,
  localparam int ID_W          = id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ-1:0]          req_cin,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_sum,
  output logic                        rsp_cout,
  output logic                        rsp_overflow,
  output logic                        busy
);

  localparam int CNT_W = id_width(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("adder_rr_scheduler: SETTLE_CYCLES must be at least 1");
  end
  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
    $error("adder_rr_scheduler: NUM_REQ must be in 1..16");
  end

  state_t              state_reg;
  logic [ID_W-1:0]     ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic                cin_reg;
  logic [ID_W-1:0]     id_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_sum_reg;
  logic                rsp_cout_reg;
  logic                rsp_overflow_reg;
  logic                busy_reg;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_req;
  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic                add_overflow;
  logic [ID_W-1:0]     ptr_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // The operand registers feed the adder directly. Nothing else drives it.
  RippleCarryAdder #(.W(DATA_W)) u_add (
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_overflow = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                        (add_sum[DATA_W-1] != a_reg[DATA_W-1]);

  assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // The grant is combinational in IDLE, so it must be masked while reset is held.
  assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      cnt_reg          <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      cin_reg          <= 1'b0;
      id_reg           <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_sum_reg      <= '0;
      rsp_cout_reg     <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            a_reg     <= req_a[grant_idx*DATA_W +: DATA_W];
            b_reg     <= req_b[grant_idx*DATA_W +: DATA_W];
            cin_reg   <= req_cin[grant_idx];
            id_reg    <= grant_idx;
            cnt_reg   <= CNT_W'(SETTLE_CYCLES - 1);
            ptr_reg   <= ptr_next;
            busy_reg  <= 1'b1;
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rsp_sum_reg      <= add_sum;
            rsp_cout_reg     <= add_cout;
            rsp_overflow_reg <= add_overflow;
            rsp_valid_reg    <= 1'b1;
            state_reg        <= RESP;
          end
        end
        RESP: begin
          if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = id_reg;
  assign rsp_sum      = rsp_sum_reg;
  assign rsp_cout     = rsp_cout_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign busy         = busy_reg;

endmodule
